// File: rtl/accelerator_pkg.sv
// Shared definitions for the vector accelerator front end.
//   vsew_e      : element-width encoding carried on req_vsew
//   LANES       : number of 32-bit processing-element lanes per beat
//   seq_state_e : beat sequencer state encoding
package accelerator_pkg;

   localparam int unsigned LANES  = 4;
   localparam int unsigned LANE_W = 32;

   typedef enum logic [1:0] {
      SEW8     = 2'd0,
      SEW16    = 2'd1,
      SEW32    = 2'd2,
      SEW_RSVD = 2'd3
   } vsew_e;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_ISSUE = 1'b1
   } seq_state_e;

endpackage

// File: rtl/lane_en_gen.sv
// Combinational tail/head lane-enable and last-beat decode for one beat.
// Ports:
//   beat_idx_i : beat number being decoded
//   vl_i       : clamped element count of the instruction
//   vstart_i   : first active element (tie to 0 when unused)
//   lane_en_o  : per-lane element enable
//   last_o     : beat_idx_i is the final beat of the instruction
module lane_en_gen
   import accelerator_pkg::*;
#(
   parameter int unsigned MAX_VL = 64
) (
   input  logic [$clog2(MAX_VL/LANES)-1:0] beat_idx_i,
   input  logic [$clog2(MAX_VL+1)-1:0]     vl_i,
   input  logic [$clog2(MAX_VL+1)-1:0]     vstart_i,
   output logic [LANES-1:0]                lane_en_o,
   output logic                            last_o
);

   localparam int unsigned VL_W = $clog2(MAX_VL+1);
   // One extra bit so element indices never wrap during comparison.
   localparam int unsigned EW   = VL_W + 1;

   logic [EW-1:0] elem_base;

   assign elem_base = EW'(beat_idx_i) << 2;

   // Element 4*idx+i is live when it lies in [vstart, vl).
   always_comb begin
      lane_en_o = '0;
      for (int unsigned i = 0; i < LANES; i++) begin
         lane_en_o[i] = ((elem_base + EW'(i)) < EW'(vl_i)) &&
                        ((elem_base + EW'(i)) >= EW'(vstart_i));
      end
   end

   // Last beat holds element vl-1.
   assign last_o = (vl_i != '0) &&
                   (EW'(beat_idx_i) == ((EW'(vl_i) - EW'(1)) >> 2));

endmodule

// File: rtl/vec_beat_sequencer.sv
// Walks one vector instruction through the four PE lanes, one 128-bit beat
// per handshake, with tail lane enables and a lane-replicated scalar operand.
// Optional feature macro: AVA_VSTART_EN adds req_vstart (start element).
// Ports:
//   clk, n_reset         : clock, synchronous active-low reset
//   req_*                : instruction request (valid/ready handshake)
//   beat_*               : beat stream to RF read / PE array (valid/ready)
//   done                 : one-cycle pulse, instruction complete
//   err                  : one-cycle pulse, reserved vsew request dropped
module vec_beat_sequencer
   import accelerator_pkg::*;
#(
   parameter int unsigned MAX_VL = 64,
   parameter int unsigned ADDR_W = 5
) (
   input  logic                            clk,
   input  logic                            n_reset,
   input  logic                            req_valid,
   output logic                            req_ready,
   input  logic [$clog2(MAX_VL+1)-1:0]     req_vl,
   input  logic [1:0]                      req_vsew,
   input  logic                            req_us,
   input  logic                            req_vx,
   input  logic [31:0]                     req_scalar,
   input  logic [ADDR_W-1:0]               req_base,
`ifdef AVA_VSTART_EN
   input  logic [$clog2(MAX_VL+1)-1:0]     req_vstart,
`endif
   output logic                            beat_valid,
   input  logic                            beat_ready,
   output logic [ADDR_W-1:0]               beat_addr,
   output logic [$clog2(MAX_VL/LANES)-1:0] beat_idx,
   output logic [LANES-1:0]                beat_lane_en,
   output logic                            beat_last,
   output logic                            beat_vx,
   output logic [LANES*LANE_W-1:0]         beat_opb,
   output logic                            done,
   output logic                            err
);

   localparam int unsigned VL_W  = $clog2(MAX_VL+1);
   localparam int unsigned IDX_W = $clog2(MAX_VL/LANES);
   localparam int unsigned OPB_W = LANES * LANE_W;

   seq_state_e        state_q, state_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [VL_W-1:0]   vl_q, vl_d;
   logic [VL_W-1:0]   vstart_q, vstart_d;
   logic              vx_q, vx_d;
   logic [OPB_W-1:0]  opb_q, opb_d;
   logic [LANES-1:0]  lane_en_q, lane_en_d;
   logic              last_q, last_d;
   logic              done_q, done_d;
   logic              err_q, err_d;

   logic [VL_W-1:0]   vl_clamp_c;
   logic [VL_W-1:0]   vstart_in_c;
   logic [LANE_W-1:0] lane_c;
   logic [OPB_W-1:0]  opb_c;
   logic [LANES-1:0]  lane_en_c;
   logic              last_c;
   vsew_e             vsew_c;

   assign vl_clamp_c = (req_vl > VL_W'(MAX_VL)) ? VL_W'(MAX_VL) : req_vl;
   assign vsew_c     = vsew_e'(req_vsew);

`ifdef AVA_VSTART_EN
   assign vstart_in_c = req_vstart;
`else
   assign vstart_in_c = '0;
`endif

   // Scalar extension to one lane, then replicated across all lanes.
   always_comb begin
      lane_c = req_scalar;
      case (vsew_c)
         SEW8:    lane_c = req_us ? {24'd0, req_scalar[7:0]}
                                  : {{24{req_scalar[7]}}, req_scalar[7:0]};
         SEW16:   lane_c = req_us ? {16'd0, req_scalar[15:0]}
                                  : {{16{req_scalar[15]}}, req_scalar[15:0]};
         default: lane_c = req_scalar;
      endcase
      opb_c = {LANES{lane_c}};
   end

   // State register and datapath registers.
   always_ff @(posedge clk) begin
      if (!n_reset) begin
         state_q   <= ST_IDLE;
         idx_q     <= '0;
         addr_q    <= '0;
         vl_q      <= '0;
         vstart_q  <= '0;
         vx_q      <= 1'b0;
         opb_q     <= '0;
         lane_en_q <= '0;
         last_q    <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         addr_q    <= addr_d;
         vl_q      <= vl_d;
         vstart_q  <= vstart_d;
         vx_q      <= vx_d;
         opb_q     <= opb_d;
         lane_en_q <= lane_en_d;
         last_q    <= last_d;
         done_q    <= done_d;
         err_q     <= err_d;
      end
   end

   // Next-state: accept in IDLE, advance beat index on each handshake.
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      addr_d   = addr_q;
      vl_d     = vl_q;
      vstart_d = vstart_q;
      vx_d     = vx_q;
      opb_d    = opb_q;
      done_d   = 1'b0;
      err_d    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               if (vsew_c == SEW_RSVD) begin
                  err_d = 1'b1;
               end else if (vstart_in_c >= vl_clamp_c) begin
                  // Nothing to issue (vl=0 or vstart past the end).
                  done_d = 1'b1;
               end else begin
                  state_d  = ST_ISSUE;
                  idx_d    = IDX_W'(vstart_in_c >> 2);
                  addr_d   = req_base + ADDR_W'(IDX_W'(vstart_in_c >> 2));
                  vl_d     = vl_clamp_c;
                  vstart_d = vstart_in_c;
                  vx_d     = req_vx;
                  opb_d    = opb_c;
               end
            end
         end
         ST_ISSUE: begin
            if (beat_ready) begin
               if (last_q) begin
                  state_d = ST_IDLE;
                  done_d  = 1'b1;
               end else begin
                  idx_d  = idx_q + IDX_W'(1);
                  addr_d = addr_q + ADDR_W'(1);
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Lane enables are decoded from the next index so they register with it.
   lane_en_gen #(
      .MAX_VL (MAX_VL)
   ) u_lane_en_gen (
      .beat_idx_i (idx_d),
      .vl_i       (vl_d),
      .vstart_i   (vstart_d),
      .lane_en_o  (lane_en_c),
      .last_o     (last_c)
   );

   always_comb begin
      lane_en_d = '0;
      last_d    = 1'b0;
      if (state_d == ST_ISSUE) begin
         lane_en_d = lane_en_c;
         last_d    = last_c;
      end
   end

   assign req_ready    = (state_q == ST_IDLE);
   assign beat_valid   = (state_q == ST_ISSUE);
   assign beat_addr    = addr_q;
   assign beat_idx     = idx_q;
   assign beat_lane_en = lane_en_q;
   assign beat_last    = last_q;
   assign beat_vx      = vx_q;
   assign beat_opb     = opb_q;
   assign done         = done_q;
   assign err          = err_q;

endmodule

// File: tb/tb_vec_beat_sequencer.sv
// Scoreboard bench for vec_beat_sequencer: directed requests push hand-computed
// beats/events; a negedge monitor pops and compares whatever the DUT presents.
module tb_vec_beat_sequencer;

   localparam int unsigned MAX_VL = 64;
   localparam int unsigned ADDR_W = 5;

   logic         clk = 1'b0;
   logic         n_reset;
   logic         req_valid;
   logic         req_ready;
   logic [6:0]   req_vl;
   logic [1:0]   req_vsew;
   logic         req_us;
   logic         req_vx;
   logic [31:0]  req_scalar;
   logic [4:0]   req_base;
`ifdef AVA_VSTART_EN
   logic [6:0]   req_vstart;
`endif
   logic         beat_valid;
   logic         beat_ready;
   logic [4:0]   beat_addr;
   logic [3:0]   beat_idx;
   logic [3:0]   beat_lane_en;
   logic         beat_last;
   logic         beat_vx;
   logic [127:0] beat_opb;
   logic         done;
   logic         err;

   vec_beat_sequencer #(
      .MAX_VL (MAX_VL),
      .ADDR_W (ADDR_W)
   ) dut (
      .clk          (clk),
      .n_reset      (n_reset),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_vl       (req_vl),
      .req_vsew     (req_vsew),
      .req_us       (req_us),
      .req_vx       (req_vx),
      .req_scalar   (req_scalar),
      .req_base     (req_base),
`ifdef AVA_VSTART_EN
      .req_vstart   (req_vstart),
`endif
      .beat_valid   (beat_valid),
      .beat_ready   (beat_ready),
      .beat_addr    (beat_addr),
      .beat_idx     (beat_idx),
      .beat_lane_en (beat_lane_en),
      .beat_last    (beat_last),
      .beat_vx      (beat_vx),
      .beat_opb     (beat_opb),
      .done         (done),
      .err          (err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct packed {
      logic [4:0]   addr;
      logic [3:0]   idx;
      logic [3:0]   en;
      logic         last;
      logic         vx;
      logic [127:0] opb;
   } beat_t;

   // kind 1 = done, 2 = err; cyc < 0 means "one cycle after the last beat"
   typedef struct {
      int kind;
      int cyc;
   } ev_t;

   beat_t exp_q[$];
   ev_t   ev_q[$];
   int    hs_q[$];
   int    last_hs = -10;
   int    total   = 0;
   int    bad     = 0;
   beat_t mon_b;
   ev_t   mon_e;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic push_beat(input logic [4:0] addr, input logic [3:0] idx, input logic [3:0] en,
                            input logic last, input logic vx, input logic [127:0] opb);
      beat_t b;
      b.addr = addr; b.idx = idx; b.en = en; b.last = last; b.vx = vx; b.opb = opb;
      exp_q.push_back(b);
   endtask

   // ev_kind: 0 none, 1 done after beats, 2 immediate done, 3 immediate err
   task automatic issue_req(input logic [6:0] vl, input logic [1:0] vsew, input logic us,
                            input logic vx, input logic [31:0] scalar, input logic [4:0] base,
                            input logic [6:0] vstart, input int ev_kind);
      int  n = 0;
      ev_t e;
      if (ev_kind != 0) begin
         e.kind = (ev_kind == 3) ? 2 : 1;
         e.cyc  = -1;
         ev_q.push_back(e);
      end
      while (!req_ready && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      chk("req_ready_wait", req_ready, 1'b1);
      req_valid  = 1'b1;
      req_vl     = vl;
      req_vsew   = vsew;
      req_us     = us;
      req_vx     = vx;
      req_scalar = scalar;
      req_base   = base;
`ifdef AVA_VSTART_EN
      req_vstart = vstart;
`else
      if (vstart != 7'd0) $display("note: vstart ignored in this build");
`endif
      @(posedge clk); #1;
      req_valid = 1'b0;
      if (ev_kind >= 2) ev_q[ev_q.size()-1].cyc = cyc;
   endtask

   task automatic wait_quiet();
      int n = 0;
      while ((exp_q.size() != 0 || ev_q.size() != 0) && n < 300) begin
         @(posedge clk); #1;
         n++;
      end
      chk("drain_timeout", (n < 300), 1'b1);
      repeat (2) begin
         @(posedge clk); #1;
      end
   endtask

   // Monitor: compare every presented beat (held or taken) and every pulse.
   always @(negedge clk) begin
      if (n_reset) begin
         if (beat_valid) begin
            if (exp_q.size() == 0) begin
               chk("beat_unexpected", 1'b1, 1'b0);
            end else begin
               mon_b = exp_q[0];
               chk("beat_addr",    beat_addr,    mon_b.addr);
               chk("beat_idx",     beat_idx,     mon_b.idx);
               chk("beat_lane_en", beat_lane_en, mon_b.en);
               chk("beat_last",    beat_last,    mon_b.last);
               chk("beat_vx",      beat_vx,      mon_b.vx);
               chk("beat_opb",     beat_opb,     mon_b.opb);
               if (beat_ready) begin
                  void'(exp_q.pop_front());
                  hs_q.push_back(cyc);
                  if (mon_b.last) last_hs = cyc;
               end
            end
         end
         if (done) begin
            if (ev_q.size() == 0) begin
               chk("done_unexpected", 1'b1, 1'b0);
            end else begin
               mon_e = ev_q.pop_front();
               chk("done_kind", mon_e.kind, 1);
               chk("done_cycle", cyc, (mon_e.cyc < 0) ? last_hs + 1 : mon_e.cyc);
            end
         end
         if (err) begin
            if (ev_q.size() == 0) begin
               chk("err_unexpected", 1'b1, 1'b0);
            end else begin
               mon_e = ev_q.pop_front();
               chk("err_kind", mon_e.kind, 2);
               chk("err_cycle", cyc, mon_e.cyc);
            end
         end
      end
   end

   int gap;

   initial begin
      n_reset    = 1'b0;
      req_valid  = 1'b0;
      req_vl     = '0;
      req_vsew   = '0;
      req_us     = 1'b0;
      req_vx     = 1'b0;
      req_scalar = '0;
      req_base   = '0;
`ifdef AVA_VSTART_EN
      req_vstart = '0;
`endif
      beat_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_beat_valid", beat_valid,   1'b0);
      chk("rst_done",       done,         1'b0);
      chk("rst_err",        err,          1'b0);
      chk("rst_beat_idx",   beat_idx,     4'd0);
      chk("rst_lane_en",    beat_lane_en, 4'd0);
      chk("rst_last",       beat_last,    1'b0);
      chk("rst_vx",         beat_vx,      1'b0);
      chk("rst_opb",        beat_opb,     128'd0);
      chk("rst_addr",       beat_addr,    5'd0);
      chk("rst_req_ready",  req_ready,    1'b1);
      n_reset = 1'b1;

      // vl=10, 8-bit signed scalar 0x80, three beats with tail 0011
      beat_ready = 1'b1;
      push_beat(5'd0, 4'd0, 4'b1111, 1'b0, 1'b1, {4{32'hFFFF_FF80}});
      push_beat(5'd1, 4'd1, 4'b1111, 1'b0, 1'b1, {4{32'hFFFF_FF80}});
      push_beat(5'd2, 4'd2, 4'b0011, 1'b1, 1'b1, {4{32'hFFFF_FF80}});
      issue_req(7'd10, 2'd0, 1'b0, 1'b1, 32'h0000_0080, 5'd0, 7'd0, 1);
      wait_quiet();

      // vl=0 -> done only; reserved vsew -> err only
      issue_req(7'd0, 2'd2, 1'b0, 1'b0, 32'h5, 5'd4, 7'd0, 2);
      issue_req(7'd8, 2'd3, 1'b0, 1'b1, 32'h5, 5'd4, 7'd0, 3);
      wait_quiet();

      // Stall on beat 0 for three cycles, address wraps 31 -> 0
      beat_ready = 1'b0;
      push_beat(5'd31, 4'd0, 4'b1111, 1'b0, 1'b0, {4{32'h0000_8765}});
      push_beat(5'd0,  4'd1, 4'b1111, 1'b1, 1'b0, {4{32'h0000_8765}});
      issue_req(7'd8, 2'd1, 1'b1, 1'b0, 32'h1234_8765, 5'd31, 7'd0, 1);
      repeat (3) begin
         @(posedge clk); #1;
      end
      chk("stall_addr_held", beat_addr, 5'd31);
      beat_ready = 1'b1;
      wait_quiet();

      // Back-to-back single-beat instructions
      hs_q.delete();
      push_beat(5'd3, 4'd0, 4'b1111, 1'b1, 1'b1, {4{32'hDEAD_BEEF}});
      issue_req(7'd4, 2'd2, 1'b0, 1'b1, 32'hDEAD_BEEF, 5'd3, 7'd0, 1);
      push_beat(5'd10, 4'd0, 4'b1111, 1'b1, 1'b0, {4{32'hFFFF_8001}});
      issue_req(7'd4, 2'd1, 1'b0, 1'b0, 32'h0000_8001, 5'd10, 7'd0, 1);
      wait_quiet();
      gap = (hs_q.size() == 2) ? hs_q[1] - hs_q[0] : -1;
      chk("b2b_gap", gap, 2);

      // Reset in the middle of a vl=64 instruction
      for (int i = 0; i < 4; i++)
         push_beat(5'(i), 4'(i), 4'b1111, 1'b0, 1'b0, {4{32'h0000_00AB}});
      issue_req(7'd64, 2'd0, 1'b1, 1'b0, 32'h0000_00AB, 5'd0, 7'd0, 0);
      repeat (3) begin
         @(posedge clk); #1;
      end
      beat_ready = 1'b0;
      chk("pre_rst_idx", beat_idx, 4'd3);
      n_reset = 1'b0;
      @(posedge clk); #1;
      chk("midrst_beat_valid", beat_valid,   1'b0);
      chk("midrst_done",       done,         1'b0);
      chk("midrst_req_ready",  req_ready,    1'b1);
      chk("midrst_lane_en",    beat_lane_en, 4'd0);
      exp_q.delete();
      n_reset    = 1'b1;
      beat_ready = 1'b1;

      // New request after reset: vl=5, 16-bit signed 0x7FFF, tail 0001
      push_beat(5'd0, 4'd0, 4'b1111, 1'b0, 1'b0, {4{32'h0000_7FFF}});
      push_beat(5'd1, 4'd1, 4'b0001, 1'b1, 1'b0, {4{32'h0000_7FFF}});
      issue_req(7'd5, 2'd1, 1'b0, 1'b0, 32'h0000_7FFF, 5'd0, 7'd0, 1);
      wait_quiet();

`ifdef AVA_VSTART_EN
      // vl=12, vstart=5: beats 1 and 2 only
      push_beat(5'd1, 4'd1, 4'b1110, 1'b0, 1'b0, {4{32'h0000_0001}});
      push_beat(5'd2, 4'd2, 4'b1111, 1'b1, 1'b0, {4{32'h0000_0001}});
      issue_req(7'd12, 2'd2, 1'b0, 1'b0, 32'h0000_0001, 5'd0, 7'd5, 1);
      // vstart >= vl: done only
      issue_req(7'd4, 2'd2, 1'b0, 1'b0, 32'h0, 5'd0, 7'd4, 2);
      wait_quiet();
`endif

      chk("exp_q_empty", exp_q.size(), 0);
      chk("ev_q_empty",  ev_q.size(),  0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/vec_beat_sequencer.md
# vec_beat_sequencer

Sequences one vector instruction's element stream through the four 32-bit processing-element lanes, issuing one 128-bit beat (four elements, one per lane) per handshake. It latches the instruction parameters, walks the beat index, computes tail lane enables from `vl`, and presents the sign- or zero-extended, lane-replicated scalar operand for vector-scalar forms. It sits between the instruction decode/dispatch stage and the vector register file read / PE array.

## Interface
- `MAX_VL`, default 64: maximum supported vector length in elements; must be a multiple of 4.
- `ADDR_W`, default 5: register-file beat address width.
- `clk`  in  1  clock.
- `n_reset`  in  1  reset, synchronous, active-low.
- `req_valid`  in  1  instruction request valid.
- `req_ready`  out  1  sequencer can accept a request.
- `req_vl`  in  $clog2(MAX_VL+1)  element count.
- `req_vsew`  in  2  element width: 0=8b, 1=16b, 2=32b, 3=reserved.
- `req_us`  in  1  unsigned scalar extension.
- `req_vx`  in  1  operand B is the scalar.
- `req_scalar`  in  32  scalar operand.
- `req_base`  in  ADDR_W  register-file address of beat 0.
- `beat_valid`  out  1  beat outputs valid.
- `beat_ready`  in  1  PE array accepts the beat.
- `beat_addr`  out  ADDR_W  `req_base + beat_idx`, wrapping modulo 2^ADDR_W.
- `beat_idx`  out  $clog2(MAX_VL/4)  beat number.
- `beat_lane_en`  out  4  per-lane element enable.
- `beat_last`  out  1  final beat of the instruction.
- `beat_vx`  out  1  latched `req_vx`.
- `beat_opb`  out  128  replicated scalar operand.
- `done`  out  1  one-cycle pulse, instruction complete.
- `err`  out  1  one-cycle pulse, reserved `vsew` request dropped.

## Operation
- States: IDLE, ISSUE.
- IDLE: `req_ready`=1. On `req_valid`: latch all request fields; clamp `vl` to MAX_VL; beat count N = ceil(vl/4).
  - vsew=3: stay IDLE, pulse `err` next cycle, no beats, no `done`.
  - N=0: stay IDLE, pulse `done` next cycle.
  - Otherwise go to ISSUE with `beat_idx`=0.
- ISSUE: `beat_valid`=1, `req_ready`=0. On `beat_ready`: if `beat_idx`=N-1, go to IDLE and pulse `done`; else increment `beat_idx`.
- Lane enable: `beat_lane_en[i]` = (4*beat_idx + i < vl). `beat_last` = (beat_idx = N-1).
- `beat_opb` is computed once at accept and held. Each 32-bit lane equals:
  - vsew=0: `scalar[7:0]` extended to 32 bits.
  - vsew=1: `scalar[15:0]` extended to 32 bits.
  - vsew=2: `scalar` unchanged.
  - Extension is zero when `us`=1, sign otherwise.
- Reset values: state IDLE, `beat_valid`=0, `done`=0, `err`=0, `beat_idx`=0, `beat_lane_en`=0, `beat_last`=0, `beat_vx`=0, `beat_opb`=0, `beat_addr`=0.
- Reset mid-instruction abandons it with no `done` pulse; `beat_valid`=0 after the reset edge.

## Timing
- Request accepted at edge T: beat 0 valid in cycle T+1.
- One beat per cycle while `beat_ready`=1.
- All `beat_*` outputs are registered and stable while `beat_valid` && !`beat_ready`.
- `done` is asserted in the cycle after the last beat's handshake. `req_ready` is also high in that cycle, so a new request can be accepted then; its beat 0 appears the following cycle. No bubble beyond that.
- `req_*` inputs are ignored outside IDLE.

## Configuration
- `AVA_VSTART_EN` defined:
  - Adds port `req_vstart`  in  $clog2(MAX_VL+1).
  - First beat is vstart>>2.
  - Lanes with element index < vstart are disabled.
  - vstart >= vl behaves as N=0: `done` only.
- `AVA_VSTART_EN` undefined: the port is absent and issue starts at element 0.

## Structure
- Shared package `accelerator_pkg` holds:
  - the `vsew` encoding enum (`SEW8`, `SEW16`, `SEW32`);
  - the `LANES`=4 constant;
  - the sequencer state enum.
- Sub-module `lane_en_gen` (combinational) computes `beat_lane_en` and `beat_last` from beat index, vl, and (optionally) vstart.
- Scalar replication is coded inline in the accept path.

## Test plan
- vl=10, vsew=0, vx, us=0, scalar=0x80, `beat_ready` tied high:
  - 3 beats with `beat_lane_en` 1111, 1111, 0011;
  - `beat_last` on beat 2;
  - each `beat_opb` lane = 0xFFFFFF80;
  - `done` pulses one cycle after beat 2.
- vl=0, then vsew=3: `done` pulse only for the first, `err` pulse only for the second; no `beat_valid` for either.
- vl=8, base=31 (ADDR_W=5), `beat_ready` low for 3 cycles on beat 0: outputs held; `beat_addr` 31 then 0.
- Back-to-back requests vl=4 and vl=4, `beat_ready` high: beats in consecutive-but-one cycles; two `done` pulses.
- Reset asserted in the middle of a vl=64 instruction: `beat_valid`=0 next cycle, no `done`; a new request is accepted afterwards.
- `AVA_VSTART_EN` defined, vl=12, vstart=5: beats 1 and 2 only, with `beat_lane_en` 1110 then 1111.
